// File: rtl/board_io_pkg.sv
// Shared constants for the Nexys4 DDR board input conditioning path.
package board_io_pkg;

  localparam int DEBOUNCE_10MS_80MHZ = 800000;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int NEXYS4_NUM_SW       = 16;

endpackage

// File: rtl/debounce_cell.sv
// One raw pin: synchroniser chain followed by a counter-based debouncer.
// update_o is combinational and marks the edge on which level_o takes the new value.
module debounce_cell
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_80MHZ
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic update_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   s;
  logic                   update;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  assign s      = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronised value agrees with stable restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    update   = 1'b0;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s;
      cnt_d    = '0;
      update   = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level_o  = stable_q;
  assign update_o = update;

endmodule

// File: rtl/board_input_conditioner.sv
// Debounces the centre button and slide switches and produces registered
// one-cycle event pulses aligned with the first cycle of each new level.
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int NUM_SW          = NEXYS4_NUM_SW,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_80MHZ
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              btn_i,
  input  logic [NUM_SW-1:0] sw_i,
  output logic              btn_level_o,
  output logic              btn_press_o,
  output logic              btn_release_o,
  output logic [NUM_SW-1:0] sw_o,
  output logic              sw_changed_o
);

  logic              btn_upd;
  logic [NUM_SW-1:0] sw_upd;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              changed_q, changed_d;

  debounce_cell #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_cell (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .d_i      (btn_i),
    .level_o  (btn_level_o),
    .update_o (btn_upd)
  );

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_cell (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .d_i      (sw_i[i]),
      .level_o  (sw_o[i]),
      .update_o (sw_upd[i])
    );
  end

  // An update always moves stable to the opposite value, so the new level is ~btn_level_o.
  assign press_d   = btn_upd & ~btn_level_o;
  assign release_d = btn_upd &  btn_level_o;
  assign changed_d = |sw_upd;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      changed_q <= changed_d;
    end
  end

  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign sw_changed_o  = changed_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Bench for board_input_conditioner: windowed reference model, per-cycle compare, directed scenarios.
module tb_board_input_conditioner;

  localparam int NSW  = 16;
  localparam int SYNC = 2;
  localparam int DC   = 4;
  localparam int NIN  = NSW + 1;

  logic           clk = 1'b0;
  logic           rst_i = 1'b0;
  logic           btn_i = 1'b0;
  logic [NSW-1:0] sw_i = '0;
  logic           btn_level_o, btn_press_o, btn_release_o, sw_changed_o;
  logic [NSW-1:0] sw_o;

  int total = 0;
  int bad   = 0;

  board_input_conditioner #(
    .NUM_SW          (NSW),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .btn_i         (btn_i),
    .sw_i          (sw_i),
    .btn_level_o   (btn_level_o),
    .btn_press_o   (btn_press_o),
    .btn_release_o (btn_release_o),
    .sw_o          (sw_o),
    .sw_changed_o  (sw_changed_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a pin's synchronised value is the raw value SYNC edges
  // earlier; a new level is accepted once the last DC synchronised samples
  // all disagree with the accepted level.
  logic [NIN-1:0] pipe [SYNC];
  logic [NIN-1:0] shist [$];
  logic [NIN-1:0] stab = '0;
  logic           e_press = 1'b0, e_rel = 1'b0, e_chg = 1'b0;
  bit             model_ok = 1'b0;

  initial begin
    logic [NIN-1:0] s, upd;
    bit all_diff;
    forever begin
      @(posedge clk);
      if (rst_i) begin
        for (int k = 0; k < SYNC; k++) pipe[k] = '0;
        shist.delete();
        stab = '0;
        e_press = 1'b0;
        e_rel = 1'b0;
        e_chg = 1'b0;
        model_ok = 1'b1;
      end else begin
        s = pipe[SYNC-1];
        shist.push_back(s);
        if (shist.size() > DC) void'(shist.pop_front());
        upd = '0;
        if (shist.size() == DC) begin
          for (int b = 0; b < NIN; b++) begin
            all_diff = 1'b1;
            foreach (shist[j]) if (shist[j][b] == stab[b]) all_diff = 1'b0;
            upd[b] = all_diff;
          end
        end
        e_press = upd[NSW] & s[NSW];
        e_rel   = upd[NSW] & ~s[NSW];
        e_chg   = |upd[NSW-1:0];
        stab    = stab ^ upd;
        for (int k = SYNC - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = {btn_i, sw_i};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (model_ok) begin
        chk("m_btn_level", 32'(btn_level_o), 32'(stab[NSW]));
        chk("m_sw", 32'(sw_o), 32'(stab[NSW-1:0]));
        chk("m_press", 32'(btn_press_o), 32'(e_press));
        chk("m_release", 32'(btn_release_o), 32'(e_rel));
        chk("m_changed", 32'(sw_changed_o), 32'(e_chg));
      end
    end
  end

  initial begin
    int pulses;
    logic [7:0] bounce;

    // Reset state
    rst_i = 1'b1;
    tick(3);
    chk("rst_level", 32'(btn_level_o), 32'd0);
    chk("rst_sw", 32'(sw_o), 32'd0);
    chk("rst_pulses", 32'({btn_press_o, btn_release_o, sw_changed_o}), 32'd0);
    rst_i = 1'b0;
    tick(4);

    // Clean press
    btn_i = 1'b1;
    tick(5);
    chk("press_e5_level", 32'(btn_level_o), 32'd0);
    chk("press_e5_pulse", 32'(btn_press_o), 32'd0);
    tick(1);
    chk("press_e6_level", 32'(btn_level_o), 32'd1);
    chk("press_e6_pulse", 32'(btn_press_o), 32'd1);
    chk("press_e6_rel", 32'(btn_release_o), 32'd0);
    tick(1);
    chk("press_e7_pulse", 32'(btn_press_o), 32'd0);
    chk("press_e7_level", 32'(btn_level_o), 32'd1);

    // Clean release
    btn_i = 1'b0;
    tick(6);
    chk("rel_e6_level", 32'(btn_level_o), 32'd0);
    chk("rel_e6_pulse", 32'(btn_release_o), 32'd1);
    chk("rel_e6_press", 32'(btn_press_o), 32'd0);
    tick(4);

    // Bounce 1,1,1,0 then 1 held
    bounce = 8'b1111_0111;
    for (int i = 0; i < 8; i++) begin
      btn_i = bounce[i];
      tick(1);
      if (i == 5) chk("bounce_e6_level", 32'(btn_level_o), 32'd0);
    end
    tick(1);
    chk("bounce_e9_level", 32'(btn_level_o), 32'd0);
    tick(1);
    chk("bounce_e10_level", 32'(btn_level_o), 32'd1);
    chk("bounce_e10_press", 32'(btn_press_o), 32'd1);
    btn_i = 1'b0;
    tick(10);

    // Short glitch
    btn_i = 1'b1;
    tick(3);
    btn_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      pulses += int'(btn_press_o) + int'(btn_level_o);
    end
    chk("glitch_no_press", 32'(pulses), 32'd0);

    // Switch pattern change
    sw_i = 16'hA5A5;
    tick(5);
    chk("sw1_e5", 32'(sw_o), 32'h0000);
    tick(1);
    chk("sw1_e6", 32'(sw_o), 32'hA5A5);
    chk("sw1_e6_chg", 32'(sw_changed_o), 32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      pulses += int'(sw_changed_o);
    end
    chk("sw1_single_pulse", 32'(pulses), 32'd0);

    sw_i = 16'hA5A4;
    tick(5);
    chk("sw2_e5", 32'(sw_o), 32'hA5A5);
    tick(1);
    chk("sw2_e6", 32'(sw_o), 32'hA5A4);
    chk("sw2_e6_chg", 32'(sw_changed_o), 32'd1);
    tick(1);
    chk("sw2_e7_chg", 32'(sw_changed_o), 32'd0);
    tick(4);

    // Reset mid-count
    btn_i = 1'b1;
    tick(4);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    tick(5);
    chk("rstmid_e5_level", 32'(btn_level_o), 32'd0);
    tick(1);
    chk("rstmid_e6_level", 32'(btn_level_o), 32'd1);
    chk("rstmid_e6_press", 32'(btn_press_o), 32'd1);
    tick(3);

    // Reset with all switches high
    btn_i = 1'b0;
    sw_i = 16'hFFFF;
    rst_i = 1'b1;
    tick(3);
    chk("rstff_level", 32'(btn_level_o), 32'd0);
    chk("rstff_sw", 32'(sw_o), 32'd0);
    chk("rstff_pulses", 32'({btn_press_o, btn_release_o, sw_changed_o}), 32'd0);
    rst_i = 1'b0;
    tick(5);
    chk("rstff_e5_sw", 32'(sw_o), 32'h0000);
    tick(1);
    chk("rstff_e6_sw", 32'(sw_o), 32'hFFFF);
    chk("rstff_e6_chg", 32'(sw_changed_o), 32'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      pulses += int'(sw_changed_o) + int'(btn_press_o);
    end
    chk("rstff_no_more", 32'(pulses), 32'd0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
